// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, holds the word for decode
// until handshake, then advances pc sequentially or by a branch offset.
module fetch_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [63:0] br_imm,
  output logic [31:0] retired,
  output logic        imem_err
);

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(IMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state;
  logic [63:0]   pc;
  logic [63:0]   pc_next;
  logic [CW-1:0] tmo_cnt;
  logic          handshake;

  assign handshake = instr_valid && instr_ready;

  // br_imm is a word offset; the shift drops its top two bits, matching mod-2^64 arithmetic.
  always_comb begin
    pc_next = pc + 64'd4;
    if (br_taken) begin
      pc_next = pc + (br_imm << 2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 32'd0;
      instr_pc    <= 64'd0;
      instr_valid <= 1'b0;
      retired     <= 32'd0;
      imem_err    <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
          tmo_cnt   <= '0;
        end
        REQ: begin
          // An ack on the final allowed cycle wins over the timeout.
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end else if (tmo_cnt == TMO_LAST) begin
            imem_req <= 1'b0;
            imem_err <= 1'b1;
            state    <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (handshake) begin
            pc          <= pc_next;
            imem_addr   <= pc_next;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            retired     <= retired + 32'd1;
            tmo_cnt     <= '0;
            state       <= REQ;
          end
        end
        ERR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          imem_err    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_req_xor_valid : assert property (@(posedge clk) disable iff (reset)
    !(imem_req && instr_valid));
  a_err_sticky : assert property (@(posedge clk) disable iff (reset)
    (state == ERR) |-> (imem_err && !imem_req));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branches, stalls, pc wrap,
// async reset mid-request and the imem timeout boundary.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [63:0] br_imm;
  logic [31:0] retired;
  logic        imem_err;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  logic [31:0] held_instr;
  logic [63:0] held_pc;

  fetch_unit #(.RESET_PC(64'h0), .IMEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_taken(br_taken), .br_imm(br_imm),
    .retired(retired), .imem_err(imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  // Single-cycle memory: acks in the first REQ cycle, then checks the held word.
  task automatic fetch(input logic [63:0] a);
    check("req_up", imem_req, 1'b1);
    check("addr", imem_addr, a);
    imem_ack   = 1'b1;
    imem_rdata = word_at(a);
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("valid_up", instr_valid, 1'b1);
    check("instr", instr, word_at(a));
    check("instr_pc", instr_pc, a);
    check("req_down", imem_req, 1'b0);
  endtask

  task automatic retire(input logic br, input logic [63:0] imm);
    instr_ready = 1'b1;
    br_taken    = br;
    br_imm      = imm;
    step();
    br_taken = 1'b0;
    br_imm   = 64'h0;
    exp_ret++;
    check("valid_down", instr_valid, 1'b0);
    check("retired", retired, exp_ret);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b1; br_taken = 1'b0; br_imm = 64'h0;
    step(); step();
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_retired", retired, 32'd0);
    check("rst_err", imem_err, 1'b0);

    // A stray ack during IDLE must not fetch anything.
    reset = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("idle_ack_ign", instr_valid, 1'b0);

    for (int i = 0; i < 9; i++) begin
      fetch(64'(i * 4));
      retire(1'b0, 64'h0);
    end
    check("addr_after_9", imem_addr, 64'h24);

    // pc 0x24 is not our target; branch to 0x20 first: 0x24 + (-1<<2) = 0x20.
    fetch(64'h24);
    retire(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    fetch(64'h20);
    retire(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    check("br_back", imem_addr, 64'h18);

    // Stall with ready low while br_taken toggles.
    fetch(64'h18);
    held_instr = word_at(64'h18);
    held_pc    = 64'h18;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      br_taken = i[0];
      br_imm   = 64'h100;
      step();
      check("stall_valid", instr_valid, 1'b1);
      check("stall_instr", instr, held_instr);
      check("stall_pc", instr_pc, held_pc);
      check("stall_req", imem_req, 1'b0);
      check("stall_ret", retired, exp_ret);
    end
    retire(1'b0, 64'h0);
    check("after_stall", imem_addr, 64'h1C);

    // 0x1C + (-8<<2) = -4, then sequential wraps to 0.
    fetch(64'h1C);
    retire(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    fetch(64'hFFFF_FFFF_FFFF_FFFC);
    retire(1'b0, 64'h0);
    fetch(64'h0);
    retire(1'b0, 64'h0);
    check("req_at_4", imem_addr, 64'h4);

    // Asynchronous reset between edges during REQ.
    #2;
    reset = 1'b1;
    #1;
    exp_ret = 0;
    check("arst_req", imem_req, 1'b0);
    check("arst_addr", imem_addr, 64'h0);
    check("arst_valid", instr_valid, 1'b0);
    check("arst_instr", instr, 32'h0);
    check("arst_ipc", instr_pc, 64'h0);
    check("arst_ret", retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    check("late_ack_valid", instr_valid, 1'b0);
    check("late_ack_req", imem_req, 1'b1);

    // Ack on the 16th REQ cycle still completes the fetch.
    for (int i = 0; i < 15; i++) step();
    check("c16_req", imem_req, 1'b1);
    check("c16_err", imem_err, 1'b0);
    fetch(64'h0);
    check("c16_err_after", imem_err, 1'b0);
    retire(1'b0, 64'h0);

    // No ack: 16 REQ cycles then ERR.
    for (int i = 0; i < 15; i++) step();
    check("t15_req", imem_req, 1'b1);
    check("t15_err", imem_err, 1'b0);
    step();
    check("tmo_err", imem_err, 1'b1);
    check("tmo_req", imem_req, 1'b0);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("err_ack_valid", instr_valid, 1'b0);
    check("err_sticky", imem_err, 1'b1);
    check("err_req", imem_req, 1'b0);
    check("err_ret", retired, 32'd1);

    reset = 1'b1;
    #1;
    check("err_clear", imem_err, 1'b0);
    step();
    reset = 1'b0;
    step();
    check("restart_req", imem_req, 1'b1);
    check("restart_addr", imem_addr, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 Parameter: IMEM_TIMEOUT, default 16, max cycles to wait for imem_ack before flagging error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  64  byte address of requested instruction.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 instr  output  32  fetched instruction to decode/sign-extend stage.
REQ-010 instr_pc  output  64  PC of instr.
REQ-011 instr_valid  output  1  instr/instr_pc valid.
REQ-012 instr_ready  input  1  decode consumes instr when valid && ready.
REQ-013 br_taken  input  1  redirect for the held instruction, sampled only at handshake.
REQ-014 br_imm  input  64  sign-extended word offset from the sign-extend stage.
REQ-015 retired  output  32  count of handshakes since reset.
REQ-016 imem_err  output  1  sticky timeout flag.

Function
REQ-017 States: IDLE, REQ, HOLD, ERR; the block SHALL leave IDLE for REQ one cycle after reset deasserts.
REQ-018 In REQ, the block SHALL assert imem_req with imem_addr = pc, holding both stable until imem_ack.
REQ-019 On imem_ack in REQ, the block SHALL register imem_rdata into instr, set instr_pc = pc and instr_valid = 1, and go to HOLD.
REQ-020 Fetch latency: instr_valid SHALL rise the cycle after imem_ack.
REQ-021 imem_ack outside REQ SHALL be ignored.
REQ-022 In HOLD, instr, instr_pc and instr_valid SHALL be held stable until instr_valid && instr_ready.
REQ-023 On handshake with br_taken = 1, next pc SHALL be pc + (br_imm << 2), modulo 2^64.
REQ-024 On handshake with br_taken = 0, next pc SHALL be pc + 4, modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal.
REQ-025 On handshake, the block SHALL clear instr_valid, increment retired (wraps at 2^32), and enter REQ the next cycle.
REQ-026 br_taken and br_imm SHALL be ignored in all cycles without a handshake.
REQ-027 Timeout counter:
- counts cycles in REQ without imem_ack, cleared on entry to REQ;
- reaching IMEM_TIMEOUT SHALL move the block to ERR and set imem_err.
REQ-028 ERR is terminal until reset: imem_req = 0, instr_valid = 0, imem_err = 1.
REQ-029 imem_ack in the same cycle the timeout counter reaches IMEM_TIMEOUT SHALL take priority; the block goes to HOLD.
REQ-030 instr_ready while instr_valid = 0 SHALL have no effect.

Reset
REQ-031 Reset assertion SHALL immediately, without waiting for a clock edge, force:
- state IDLE, pc = RESET_PC;
- imem_req = 0, imem_addr = RESET_PC;
- instr = 0, instr_pc = 0, instr_valid = 0;
- retired = 0, imem_err = 0, timeout counter = 0.
REQ-032 Reset mid-request or mid-HOLD SHALL abandon the transaction; a late imem_ack SHALL be ignored.

Verification
REQ-033 Reset release, 1-cycle memory, ready tied 1, no branches:
- imem_addr sequence 0, 4, 8, 12;
- instr matches imem_rdata;
- retired = 4 after 4 handshakes.
REQ-034 Handshake at pc = 0x20 with br_taken = 1, br_imm = 64'hFFFF_FFFF_FFFF_FFFE -> next imem_addr = 0x18.
REQ-035 instr_ready held 0 for 5 cycles -> instr/instr_pc/instr_valid stable, imem_req = 0, retired unchanged; br_taken pulses ignored.
REQ-036 Memory never acks, IMEM_TIMEOUT = 16 -> imem_err = 1 after 16 REQ cycles, imem_req = 0; reset clears imem_err.
REQ-037 Ack arriving on cycle 16 -> HOLD, imem_err stays 0.
REQ-038 Reset asserted between clock edges during REQ -> outputs at reset values before next edge; ack one cycle later ignored.
